// File: rtl/dot_product_chunk_feeder_pkg.sv
// Shared constants for the chunked dot-product feeder.
//   - FSM state encoding (IDLE, WAIT_READY, STREAM, WAIT_FIN, DONE)
//   - PAD_BEATS: zero beats appended after the data beats, because the
//     consumer counts two beats beyond length/no_of_units before it finishes
//   - default beat hold time and finish timeout
//   - length_bad(): run-length validation used when start is accepted
package dot_feeder_pkg;

    localparam logic [2:0] ST_IDLE       = 3'd0;
    localparam logic [2:0] ST_WAIT_READY = 3'd1;
    localparam logic [2:0] ST_STREAM     = 3'd2;
    localparam logic [2:0] ST_WAIT_FIN   = 3'd3;
    localparam logic [2:0] ST_DONE       = 3'd4;

    localparam int PAD_BEATS       = 2;
    localparam int DEF_BEAT_CYCLES = 2;
    localparam int DEF_FIN_TIMEOUT = 1024;

    // A run is rejected when it is empty, larger than the buffer, or not a
    // whole number of beats.
    function automatic logic length_bad(input logic [31:0] len,
                                        input int unsigned max_len,
                                        input int unsigned nu);
        return (len == 32'd0) || (len > 32'(max_len)) || ((len % 32'(nu)) != 32'd0);
    endfunction

endpackage

// File: rtl/dot_product_chunk_feeder_if.sv
// Feeder <-> dot-product controller bus.
//   master (feeder):  drives first_row_plus_additional (A chunk), vector2 (B chunk),
//                     outsider_read_now, total; receives I_am_ready, finish,
//                     dot_product_output.
//   slave  (consumer): the mirror image.
// Lane k of each chunk occupies bits [k*element_width +: element_width].
interface dot_product_chunk_feeder_if #(
    parameter int element_width = 32,
    parameter int no_of_units   = 8
);
    logic [element_width*no_of_units-1:0] first_row_plus_additional;
    logic [element_width*no_of_units-1:0] vector2;
    logic                                 outsider_read_now;
    logic [31:0]                          total;
    logic                                 I_am_ready;
    logic                                 finish;
    logic [element_width-1:0]             dot_product_output;

    modport master (
        output first_row_plus_additional, vector2, outsider_read_now, total,
        input  I_am_ready, finish, dot_product_output
    );

    modport slave (
        input  first_row_plus_additional, vector2, outsider_read_now, total,
        output I_am_ready, finish, dot_product_output
    );
endinterface

// File: rtl/dot_product_chunk_feeder_vector_buffer.sv
// Storage for the two operand vectors.
//   clk               clock (storage has no reset; contents survive reset)
//   wr_en/wr_sel      element write strobe, 0 = A, 1 = B
//   wr_addr/wr_data   element index and value
//   rd_chunk          chunk index (combinational read)
//   chunk_a/chunk_b   no_of_units consecutive elements starting at rd_chunk*no_of_units
import dot_feeder_pkg::*;

module feeder_vector_buffer #(
    parameter int element_width = 32,
    parameter int no_of_units   = 8,
    parameter int max_length    = 64,
    parameter int addr_width    = 6,
    parameter int chunk_width   = 3
) (
    input  logic                                      clk,
    input  logic                                      wr_en,
    input  logic                                      wr_sel,
    input  logic [addr_width-1:0]                     wr_addr,
    input  logic [element_width-1:0]                  wr_data,
    input  logic [chunk_width-1:0]                    rd_chunk,
    output logic [no_of_units-1:0][element_width-1:0] chunk_a,
    output logic [no_of_units-1:0][element_width-1:0] chunk_b
);
    logic [element_width-1:0] mem_a [max_length];
    logic [element_width-1:0] mem_b [max_length];
    logic [addr_width-1:0]    base;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            if (wr_sel) mem_b[wr_addr] <= wr_data;
            else        mem_a[wr_addr] <= wr_data;
        end
    end

    assign base = addr_width'(rd_chunk) * addr_width'(no_of_units);

    for (genvar k = 0; k < no_of_units; k++) begin : g_lane
        assign chunk_a[k] = mem_a[base + addr_width'(k)];
        assign chunk_b[k] = mem_b[base + addr_width'(k)];
    end

endmodule

// File: rtl/dot_product_chunk_feeder.sv
// Producer side of the chunked dot-product interface. Buffers vectors A and B,
// streams them no_of_units elements per beat to the consumer, waits for its
// finish and hands the scalar result back to the host.
//   clk, reset            clock, synchronous active-low reset
//   wr_en/wr_sel/wr_addr/wr_data   host element writes (dropped while busy)
//   start, length         run request (sampled in IDLE only)
//   busy, done, error     run status; done/error are single-cycle pulses
//   result                consumer result, held until the next done
//   cons                  consumer bus (master side)
import dot_feeder_pkg::*;

module dot_product_chunk_feeder #(
    parameter int element_width = 32,
    parameter int no_of_units   = 8,
    parameter int max_length    = 64,
    parameter int addr_width    = 6,
    parameter int beat_cycles   = DEF_BEAT_CYCLES,
    parameter int fin_timeout   = DEF_FIN_TIMEOUT
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      wr_en,
    input  logic                      wr_sel,
    input  logic [addr_width-1:0]     wr_addr,
    input  logic [element_width-1:0]  wr_data,
    input  logic                      start,
    input  logic [31:0]               length,
    output logic                      busy,
    output logic                      done,
    output logic                      error,
    output logic [element_width-1:0]  result,
    dot_product_chunk_feeder_if.master cons
);
    localparam int MAX_CHUNKS = max_length / no_of_units;
    localparam int CHUNK_W    = (MAX_CHUNKS > 1) ? $clog2(MAX_CHUNKS) : 1;
    localparam int BEAT_W     = $clog2(MAX_CHUNKS + PAD_BEATS + 1);
    localparam int CYC_W      = $clog2(beat_cycles + 1);
    localparam int TMO_W      = $clog2(fin_timeout + 1);
    localparam int BUS_W      = element_width * no_of_units;

    logic [2:0]                               state;
    logic [BEAT_W-1:0]                        beat_idx;
    logic [BEAT_W-1:0]                        n_beats;
    logic [BEAT_W-1:0]                        next_beat;
    logic [CYC_W-1:0]                         cyc_cnt;
    logic [TMO_W-1:0]                         tmo_cnt;
    logic [CHUNK_W-1:0]                       rd_chunk;
    logic [no_of_units-1:0][element_width-1:0] chunk_a;
    logic [no_of_units-1:0][element_width-1:0] chunk_b;
    logic [BUS_W-1:0]                         a_q, b_q;
    logic                                     read_now_q;
    logic [31:0]                              total_q;

    assign next_beat = beat_idx + BEAT_W'(1);

    // The chunk registers are loaded one clock ahead of use, so the buffer is
    // addressed with the chunk for the beat about to start (chunk 0 while
    // waiting for the consumer).
    assign rd_chunk = (state == ST_STREAM) ? next_beat[CHUNK_W-1:0] : '0;

    feeder_vector_buffer #(
        .element_width(element_width),
        .no_of_units  (no_of_units),
        .max_length   (max_length),
        .addr_width   (addr_width),
        .chunk_width  (CHUNK_W)
    ) u_buf (
        .clk     (clk),
        .wr_en   (wr_en && !busy),
        .wr_sel  (wr_sel),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_chunk(rd_chunk),
        .chunk_a (chunk_a),
        .chunk_b (chunk_b)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= ST_IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
            result     <= '0;
            read_now_q <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
            total_q    <= '0;
            beat_idx   <= '0;
            n_beats    <= '0;
            cyc_cnt    <= '0;
            tmo_cnt    <= '0;
        end else begin
            done  <= 1'b0;
            error <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        if (length_bad(length, max_length, no_of_units)) begin
                            error <= 1'b1;
                        end else begin
                            total_q <= length;
                            n_beats <= BEAT_W'(length / 32'(no_of_units));
                            busy    <= 1'b1;
                            state   <= ST_WAIT_READY;
                        end
                    end
                end
                ST_WAIT_READY: begin
                    if (cons.I_am_ready) begin
                        state      <= ST_STREAM;
                        read_now_q <= 1'b1;
                        a_q        <= chunk_a;
                        b_q        <= chunk_b;
                        beat_idx   <= '0;
                        cyc_cnt    <= '0;
                    end
                end
                ST_STREAM: begin
                    if (cyc_cnt == CYC_W'(beat_cycles - 1)) begin
                        cyc_cnt <= '0;
                        if (beat_idx == n_beats + BEAT_W'(PAD_BEATS - 1)) begin
                            state      <= ST_WAIT_FIN;
                            read_now_q <= 1'b0;
                            a_q        <= '0;
                            b_q        <= '0;
                            tmo_cnt    <= '0;
                        end else begin
                            beat_idx <= next_beat;
                            // Beats past the data are the zero pad beats.
                            if (next_beat < n_beats) begin
                                a_q <= chunk_a;
                                b_q <= chunk_b;
                            end else begin
                                a_q <= '0;
                                b_q <= '0;
                            end
                        end
                    end else begin
                        cyc_cnt <= cyc_cnt + CYC_W'(1);
                    end
                end
                ST_WAIT_FIN: begin
                    if (cons.finish) begin
                        result <= cons.dot_product_output;
                        done   <= 1'b1;
                        busy   <= 1'b0;
                        state  <= ST_DONE;
                    end else if (tmo_cnt == TMO_W'(fin_timeout - 1)) begin
                        error <= 1'b1;
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + TMO_W'(1);
                    end
                end
                ST_DONE:  state <= ST_IDLE;
                default:  state <= ST_IDLE;
            endcase
        end
    end

    assign cons.first_row_plus_additional = a_q;
    assign cons.vector2                   = b_q;
    assign cons.outsider_read_now         = read_now_q;
    assign cons.total                     = total_q;

endmodule
